instr_mem_loader: RTL and testbench

Boot-time program loader: the writing end of the CPU's 16-bit, big-endian, byte-addressed instruction memory.
- Accepts a byte stream over a valid/ready handshake and writes it byte-by-byte into instruction memory starting at the reset PC.
- Holds the CPU via Busy until the image is complete.
- Sits between an external byte source (UART/testbench) and the instruction memory write port.

---
 rtl/instr_mem_loader_if.sv | 40 ++++
 rtl/instr_mem_loader.sv | 181 ++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot-time program loader.
//
// Stream handshake: a byte transfers on a rising clock edge where both
// byte_valid and byte_ready are high. byte_ready is a registered output of
// the loader and does not depend on byte_valid in the same cycle. The source
// may hold or drop byte_valid freely. byte_in is only looked at when a
// transfer happens.
//
// Memory side: mem_write is a one-cycle strobe per byte. mem_addr/mem_data
// are meaningful while mem_write is high. mem_addr keeps its last value otherwise.
interface instr_mem_loader_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_write;

  // Byte source / memory observer side
  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_addr,
    input  mem_data,
    input  mem_write
  );

  // Loader side
  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_addr,
    output mem_data,
    output mem_write
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Boot-time program loader for the CPU's 16-bit big-endian, byte-addressed
// instruction memory.
//
// Stream format: length high byte, length low byte, then L payload bytes.
// Payload byte k is written to BASE_ADDR+k one cycle after it is accepted.
// busy holds the CPU while a load is in progress.
// done and error are sticky until the next start.
//
// Optional feature, macro LOADER_CHECKSUM_EN: one extra byte follows the payload.
// It must equal the XOR of all payload bytes, otherwise the load ends in error.
// The checksum byte is never written to memory.
//
// fsm_state is a debug view of the controller state.
// Encoding: 0 IDLE, 1 LEN_HI, 2 LEN_LO, 3 LOAD, 4 CSUM, 5 DONE, 6 ERROR.
module instr_mem_loader #(
  parameter int BASE_ADDR = 10,
  parameter int MEM_BYTES = 128,
  parameter int ADDR_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         byte_count,
  output logic [2:0]          fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_LOAD   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // Largest image that fits between the reset PC and the end of memory.
  localparam logic [15:0]       LOAD_MAX  = 16'(MEM_BYTES - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [15:0] len_new;
  logic        xfer;
  logic        last_payload;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign fsm_state = state;

  // Handshake decode and the length formed by the byte currently on the bus.
  always_comb begin
    xfer         = bus.byte_valid & bus.byte_ready;
    len_new      = {len_hi, bus.byte_in};
    last_payload = (byte_count == len - 16'd1);
  end

  // Loader controller with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      len_hi         <= 8'h00;
      len            <= 16'h0000;
      bus.byte_ready <= 1'b0;
      bus.mem_write  <= 1'b0;
      bus.mem_addr   <= BASE_A;
      bus.mem_data   <= 8'h00;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      byte_count     <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
      csum           <= 8'h00;
`endif
    end else begin
      // The write strobe lasts exactly one cycle per accepted payload byte.
      bus.mem_write <= 1'b0;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state          <= S_LEN_HI;
            bus.byte_ready <= 1'b1;
            busy           <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
            byte_count     <= 16'h0000;
`ifdef LOADER_CHECKSUM_EN
            csum           <= 8'h00;
`endif
          end
        end

        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= bus.byte_in;
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (xfer) begin
            len <= len_new;
            if (len_new[0] || (len_new > LOAD_MAX)) begin
              // Odd images cannot hold whole instructions; oversized ones
              // would run past the end of memory.
              state          <= S_ERROR;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              error          <= 1'b1;
            end else if (len_new == 16'h0000) begin
`ifdef LOADER_CHECKSUM_EN
              state          <= S_CSUM;
`else
              state          <= S_DONE;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
`endif
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (xfer) begin
            // byte_count doubles as the payload index k of this byte.
            bus.mem_write <= 1'b1;
            bus.mem_addr  <= BASE_A + byte_count[ADDR_W-1:0];
            bus.mem_data  <= bus.byte_in;
            byte_count    <= byte_count + 16'd1;
`ifdef LOADER_CHECKSUM_EN
            csum          <= csum ^ bus.byte_in;
`endif
            if (last_payload) begin
`ifdef LOADER_CHECKSUM_EN
              state          <= S_CSUM;
`else
              // The final write lands in the first DONE cycle.
              state          <= S_DONE;
              bus.byte_ready <= 1'b0;
              busy           <= 1'b0;
              done           <= 1'b1;
`endif
            end
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            bus.byte_ready <= 1'b0;
            busy           <= 1'b0;
            if (bus.byte_in == csum) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state          <= S_IDLE;
          bus.byte_ready <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// The checksum scenarios are compiled in when LOADER_CHECKSUM_EN is defined.
module tb_instr_mem_loader;
  localparam int BASE_ADDR = 10;
  localparam int MEM_BYTES = 128;
  localparam int ADDR_W    = 7;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  seed;
    bit          gap;
    bit          bad_csum;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  typedef logic [7:0] stream_t [8];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] byte_count;
  logic [2:0]  fsm_state;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus();

  instr_mem_loader #(
    .BASE_ADDR (BASE_ADDR),
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .byte_count (byte_count),
    .fsm_state  (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_pass    = 0;
  int n_total   = 0;
  int write_cnt = 0;
  logic [ADDR_W+7:0] exp_q[$];

  vec_t vecs[12];
  int   n_vec;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin : monitor
    logic [ADDR_W+7:0] e;
    if (bus.mem_write === 1'b1) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", int'(bus.mem_addr), int'(e[ADDR_W+7:8]));
        chk("write_data", int'(bus.mem_data), int'(e[7:0]));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, bus.byte_ready, 0);
    chk({tag, "_mem_write"},  bus.mem_write, 0);
    chk({tag, "_mem_addr"},   bus.mem_addr, BASE_ADDR);
    chk({tag, "_mem_data"},   bus.mem_data, 0);
    chk({tag, "_busy"},       busy, 0);
    chk({tag, "_done"},       done, 0);
    chk({tag, "_error"},      error, 0);
    chk({tag, "_byte_count"}, byte_count, 0);
    chk({tag, "_state"},      fsm_state, 0);
  endtask

  // Drivers
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", bus.byte_ready, 1);
  endtask

  // Offers one byte and returns #1 after the edge that transfers it.
  task automatic send_byte(input logic [7:0] b, input bit payload, input int idx);
    int t;
    t = 0;
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.byte_ready) begin
      chk("byte_ready_timeout", 0, 1);
      bus.byte_valid = 1'b0;
      return;
    end
    if (payload) exp_q.push_back({7'(BASE_ADDR + idx), b});
    @(posedge clk);
    #1;
    if (payload) begin
      chk("write_latency", bus.mem_write, 1);
      chk("count_with_write", byte_count, idx + 1);
    end else begin
      chk("no_write_ctrl_byte", bus.mem_write, 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic finish_checks(input int w0, input int exp_writes, input bit exp_done, input bit exp_err);
    chk("end_done",  done, exp_done);
    chk("end_error", error, exp_err);
    chk("end_busy",  busy, 0);
    chk("end_count", byte_count, exp_writes);
    idle_cycles(2);
    chk("write_total", write_cnt - w0, exp_writes);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("ready_low_after", bus.byte_ready, 0);
    chk("done_sticky", done, exp_done);
    chk("error_sticky", error, exp_err);
  endtask

  task automatic run_load(input vec_t v);
    int w0;
    logic [7:0] b;
    logic [7:0] x;
    w0 = write_cnt;
    x  = 8'h00;
    pulse_start();
    send_byte(v.len[15:8], 1'b0, 0);
    send_byte(v.len[7:0], 1'b0, 0);
    for (int i = 0; i < v.exp_writes; i++) begin
      if (v.gap && i > 0) idle_cycles(2);
      b = v.seed + 8'(i * 37);
      x = x ^ b;
      send_byte(b, 1'b1, i);
    end
`ifdef LOADER_CHECKSUM_EN
    if (v.len == 16'(v.exp_writes)) send_byte(v.bad_csum ? (x ^ 8'h5A) : x, 1'b0, 0);
`endif
    finish_checks(w0, v.exp_writes, v.exp_done, v.exp_err);
  endtask

  task automatic run_stream(input stream_t s, input int n, input int n_payload,
                            input bit exp_done, input bit exp_err);
    int w0;
    w0 = write_cnt;
    pulse_start();
    for (int i = 0; i < n; i++) begin
      if (i >= 2 && i < 2 + n_payload) send_byte(s[i], 1'b1, i - 2);
      else send_byte(s[i], 1'b0, 0);
    end
    finish_checks(w0, n_payload, exp_done, exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stream_t st;
    int w0;

    // Stimulus table: length, payload seed, gaps, bad checksum, writes, done, error
    n_vec = 0;
    vecs[n_vec++] = '{16'd4,      8'h12, 1'b0, 1'b0, 4,   1'b1, 1'b0};
    vecs[n_vec++] = '{16'd3,      8'h00, 1'b0, 1'b0, 0,   1'b0, 1'b1};
    vecs[n_vec++] = '{16'd118,    8'h01, 1'b0, 1'b0, 118, 1'b1, 1'b0};
    vecs[n_vec++] = '{16'd120,    8'h00, 1'b0, 1'b0, 0,   1'b0, 1'b1};
    vecs[n_vec++] = '{16'd6,      8'hA0, 1'b1, 1'b0, 6,   1'b1, 1'b0};
    vecs[n_vec++] = '{16'd0,      8'h00, 1'b0, 1'b0, 0,   1'b1, 1'b0};
    vecs[n_vec++] = '{16'h0102,   8'h00, 1'b0, 1'b0, 0,   1'b0, 1'b1};
    vecs[n_vec++] = '{16'h8000,   8'h00, 1'b0, 1'b0, 0,   1'b0, 1'b1};
    vecs[n_vec++] = '{16'd2,      8'h77, 1'b1, 1'b0, 2,   1'b1, 1'b0};
`ifdef LOADER_CHECKSUM_EN
    vecs[n_vec++] = '{16'd4,      8'h3C, 1'b0, 1'b1, 4,   1'b0, 1'b1};
`endif

    // Reset
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Valid bytes offered while idle must be ignored.
    @(negedge clk);
    bus.byte_in = 8'hFF;
    bus.byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ignore_state", fsm_state, 0);
    chk("idle_ignore_writes", write_cnt, 0);
    bus.byte_valid = 1'b0;

    // Back-to-back image 00 04 12 34 AB CD
    st = '{8'h00, 8'h04, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    run_stream(st, 7, 4, 1'b1, 1'b0);
`else
    run_stream(st, 6, 4, 1'b1, 1'b0);
`endif

    // Table-driven loads
    for (int i = 0; i < n_vec; i++) run_load(vecs[i]);

    // Reset in the middle of a 4-byte load, with a start ignored while busy.
    w0 = write_cnt;
    pulse_start();
    send_byte(8'h00, 1'b0, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'h55, 1'b1, 0);
    send_byte(8'h66, 1'b1, 1);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start_ignored_state", fsm_state, 3);
    chk("busy_start_ignored_count", byte_count, 2);
    chk("busy_start_ignored_busy", busy, 1);
    bus.byte_in = 8'h99;
    bus.byte_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("midload_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("midload_writes", write_cnt - w0, 2);
    chk("midload_q_empty", exp_q.size(), 0);
    run_load(vecs[0]);

`ifdef LOADER_CHECKSUM_EN
    // Checksum good and bad on the same payload
    st = '{8'h00, 8'h02, 8'h0F, 8'hF0, 8'hFF, 8'h00, 8'h00, 8'h00};
    run_stream(st, 5, 2, 1'b1, 1'b0);
    st = '{8'h00, 8'h02, 8'h0F, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00};
    run_stream(st, 5, 2, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
